// File: rtl/tri_wb_loader.sv
// Wishbone classic master that writes one triangle descriptor into the
// interp_tri register file as a 4-beat burst (regs 0..3), with per-beat ack timeout.
module tri_wb_loader #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_ax,
    input  logic [7:0]  cmd_ay,
    input  logic [7:0]  cmd_bx,
    input  logic [7:0]  cmd_by,
    input  logic [7:0]  cmd_cx,
    input  logic [7:0]  cmd_cy,
    input  logic [9:0]  cmd_delta_t,
    input  logic        cmd_bflip,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [1:0]  wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [7:0]  timer_q, timer_d;
    logic        cyc_q, cyc_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        err_q, err_d;
    logic        load;

    logic [7:0]  ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    logic [9:0]  dt_q;
    logic        bflip_q;

    function automatic logic [31:0] beat_dat(
        input logic [1:0] b,
        input logic [7:0] ax, input logic [7:0] ay,
        input logic [7:0] bx, input logic [7:0] by,
        input logic [7:0] cx, input logic [7:0] cy,
        input logic [9:0] dt, input logic bf
    );
        case (b)
            2'd0:    beat_dat = {8'h00, ay, 8'h00, ax};
            2'd1:    beat_dat = {8'h00, by, 8'h00, bx};
            2'd2:    beat_dat = {8'h00, cy, 8'h00, cx};
            default: beat_dat = {15'h0, bf, 6'h0, dt};
        endcase
    endfunction

    function automatic logic [3:0] beat_sel(input logic [1:0] b);
        beat_sel = (b == 2'd3) ? 4'b0111 : 4'b0101;
    endfunction

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        timer_d = timer_q;
        cyc_d   = cyc_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        err_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cyc_d = 1'b0;
                sel_d = 4'h0;
                adr_d = 2'd0;
                dat_d = 32'h0;
                if (cmd_valid) begin
                    // Beat 0 is driven straight from the command port on the latch edge.
                    load    = 1'b1;
                    state_d = S_WRITE;
                    beat_d  = 2'd0;
                    timer_d = 8'd0;
                    cyc_d   = 1'b1;
                    sel_d   = beat_sel(2'd0);
                    adr_d   = 2'd0;
                    dat_d   = beat_dat(2'd0, cmd_ax, cmd_ay, cmd_bx, cmd_by,
                                       cmd_cx, cmd_cy, cmd_delta_t, cmd_bflip);
                end
            end
            S_WRITE: begin
                if (wbm_ack_i) begin
                    timer_d = 8'd0;
                    if (beat_q == 2'd3) begin
                        state_d = S_DONE;
                        beat_d  = 2'd0;
                        cyc_d   = 1'b0;
                        sel_d   = 4'h0;
                        adr_d   = 2'd0;
                        dat_d   = 32'h0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        sel_d  = beat_sel(beat_q + 2'd1);
                        adr_d  = beat_q + 2'd1;
                        dat_d  = beat_dat(beat_q + 2'd1, ax_q, ay_q, bx_q, by_q,
                                          cx_q, cy_q, dt_q, bflip_q);
                    end
                end else if (timer_q == TMO_LAST) begin
                    // This missed ack would bring the wait count to TIMEOUT: abort.
                    state_d = S_IDLE;
                    beat_d  = 2'd0;
                    timer_d = 8'd0;
                    cyc_d   = 1'b0;
                    sel_d   = 4'h0;
                    adr_d   = 2'd0;
                    dat_d   = 32'h0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                sel_d   = 4'h0;
                adr_d   = 2'd0;
                dat_d   = 32'h0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
            timer_q <= 8'd0;
            cyc_q   <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 2'd0;
            dat_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            timer_q <= timer_d;
            cyc_q   <= cyc_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end
    end

    // Descriptor holding registers carry no reset; they are only read while in WRITE.
    always_ff @(posedge wb_clk_i) begin
        if (load) begin
            ax_q    <= cmd_ax;
            ay_q    <= cmd_ay;
            bx_q    <= cmd_bx;
            by_q    <= cmd_by;
            cx_q    <= cmd_cx;
            cy_q    <= cmd_cy;
            dt_q    <= cmd_delta_t;
            bflip_q <= cmd_bflip;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule
